slice_stream_ctrl: RTL and testbench
====================================

# slice_stream_ctrl

Sequencer that drives the test-vector file reader and turns its random-access output into an ordered, flow-controlled stream of 25-bit Keccak slices for the addRc datapath. On `start` it latches a file number, issues a one-cycle `read_file` load, then sweeps `line_index` 0..LINES-1. Each word is registered and presented on a valid/ready port together with its slice number and a last flag. It sits between the file reader (upstream) and the round-constant stage (downstream).

## Interface
- `LINES`, 64, number of slices per file; power of two
- `WIDTH`, 25, slice width in bits
- `FILE_W`, 10, file-number width
- `IDX_W`, $clog2(LINES) = 6, line/slice index width

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request a file pass; sampled only in IDLE
- `file_idx_in`  in  FILE_W  file number, latched with `start`
- `busy`  out  1  high whenever state != IDLE
- `read_file`  out  1  one-cycle load strobe to reader
- `file_index`  out  FILE_W  latched file number to reader
- `line_index`  out  IDX_W  read pointer to reader
- `data_in`  in  WIDTH  reader word at `line_index`; combinational, same cycle
- `out_valid`  out  1  output register holds a word
- `out_ready`  in  1  downstream accepts; transfer = valid & ready
- `out_data`  out  WIDTH  slice word
- `out_slice`  out  IDX_W  slice number of `out_data`
- `out_last`  out  1  high with slice LINES-1
- `done`  out  1  one-cycle pulse after last transfer
- `col_parity`  out  5  only with SLICE_PARITY_EN (see Configuration)

## Operation
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: `start`=1 latches `file_idx_in` into `file_index`, clears pointer, -> LOAD.
- LOAD: `read_file`=1 for exactly this cycle; -> STREAM.
- STREAM: `line_index` = pointer. Capture when pointer not exhausted and (`!out_valid` or `out_ready`): `out_data`<=`data_in`, `out_slice`<=pointer, `out_last`<=(pointer==LINES-1), `out_valid`<=1, pointer++.
- Transfer with no capture in same cycle clears `out_valid`.
- Transfer of word with `out_last`=1 -> DONE.
- DONE: `done`=1 one cycle, `out_valid`=0; -> IDLE.
- `start` outside IDLE ignored; `file_index` stable for whole pass.
- Pointer is IDX_W+1 bits to mark exhaustion; `line_index` = low IDX_W bits, holds LINES-1 after exhaustion (no wrap to 0).
- `out_data`, `out_slice`, `out_last` stable while `out_valid`=1 and `out_ready`=0.
- Reset (any state): IDLE, all outputs 0, pointer 0, `file_index` 0. Reader memory is not cleared; next pass reloads.

## Timing
- `start` sampled at edge 0 -> LOAD in cycle 1 (`read_file`=1) -> STREAM cycle 2, `line_index`=0 -> `out_valid`=1 from cycle 3.
- `out_ready` held high: slices 0..LINES-1 in cycles 3..LINES+2, one per cycle, no bubbles; `done` in cycle LINES+3; `busy` low cycle LINES+4.
- Backpressure: `out_ready`=0 stalls pointer; no word lost or duplicated.
- `out_ready` ignored when `out_valid`=0.

## Configuration
- `SLICE_PARITY_EN` defined: `col_parity[x]` = XOR of `out_data[5y+x]` for y=0..4, registered with `out_data`, reset 0, same validity.
- Undefined: `col_parity` port and logic absent.

## Test plan
- Reset mid-STREAM (slice 20 pending): all outputs 0 next cycle, state IDLE; new `start`, file 7 -> full pass from slice 0, `file_index`=7.
- `start`, file 3, `out_ready`=1: `read_file` exactly one cycle (cycle 1); 64 transfers cycles 3..66 with `out_slice` 0..63 matching input_3.txt lines; `out_last` only on 63; `done` cycle 67.
- Random `out_ready` (50%): 64 transfers in order, data held stable during stalls, no duplicates.
- `start` asserted during LOAD, STREAM and DONE with a different file number: ignored, `file_index` unchanged.
- `out_ready`=0 from cycle 3 for 10 cycles: `out_valid`=1, `out_slice`=0 held, `line_index`=1; resumes slice 1 after release.
- SLICE_PARITY_EN: slice 0x1FFFFFF -> `col_parity`=5'b11111; 0x0000001 -> 5'b00001; 0x0000021 -> 5'b00000.

Source files
------------

// File: rtl/slice_stream_ctrl.sv
// Sequences the test-vector reader and streams its words as ordered 25-bit Keccak slices.
// Optional SLICE_PARITY_EN adds a registered per-column parity output alongside out_data.
module slice_stream_ctrl #(
  parameter int LINES  = 64,
  parameter int WIDTH  = 25,
  parameter int FILE_W = 10,
  parameter int IDX_W  = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FILE_W-1:0] file_idx_in,
  output logic              busy,
  output logic              read_file,
  output logic [FILE_W-1:0] file_index,
  output logic [IDX_W-1:0]  line_index,
  input  logic [WIDTH-1:0]  data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [IDX_W-1:0]  out_slice,
  output logic              out_last,
  output logic              done
`ifdef SLICE_PARITY_EN
  ,
  output logic [4:0]        col_parity
`endif
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | one-cycle read_file strobe to the reader
  // STREAM | sweeping line_index, feeding the output register
  // DONE   | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  state_t           state, state_nx;
  logic [IDX_W:0]   ptr;
  logic             exhausted;
  logic             xfer;
  logic             capture;

  assign exhausted  = ptr[IDX_W];
  // Saturate at the final line instead of wrapping back to 0 once exhausted.
  assign line_index = exhausted ? {IDX_W{1'b1}} : ptr[IDX_W-1:0];

`ifdef SLICE_PARITY_EN
  function automatic logic [4:0] fold_parity(input logic [WIDTH-1:0] d);
    logic [4:0] p;
    p = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        p[x] = p[x] ^ d[5*y+x];
    return p;
  endfunction
`endif

  always_comb begin
    state_nx  = state;
    xfer      = out_valid && out_ready;
    capture   = (state == STREAM) && !exhausted && (!out_valid || out_ready);
    busy      = (state != IDLE);
    read_file = (state == LOAD);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = STREAM;
      STREAM:  if (xfer && out_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      file_index <= '0;
      ptr        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_slice  <= '0;
      out_last   <= 1'b0;
`ifdef SLICE_PARITY_EN
      col_parity <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        file_index <= file_idx_in;
        ptr        <= '0;
      end
      if (capture) begin
        out_data  <= data_in;
        out_slice <= ptr[IDX_W-1:0];
        out_last  <= (ptr[IDX_W-1:0] == IDX_W'(LINES-1));
        out_valid <= 1'b1;
        ptr       <= ptr + (IDX_W+1)'(1);
`ifdef SLICE_PARITY_EN
        col_parity <= fold_parity(data_in);
`endif
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slice_stream_ctrl.sv
// Self-checking bench for slice_stream_ctrl: reader model, ordered-slice scoreboard, directed passes.
// Define SLICE_PARITY_EN for both files to cover the column-parity output.
module tb_slice_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  file_idx_in;
  logic        busy, read_file, out_valid, out_ready, out_last, done;
  logic [9:0]  file_index;
  logic [5:0]  line_index, out_slice;
  logic [24:0] data_in, out_data;
`ifdef SLICE_PARITY_EN
  logic [4:0]  col_parity;
`endif

  int errors = 0;
  int checks = 0;
  int unsigned salt;
  logic [9:0] rd_file;

  slice_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .file_idx_in(file_idx_in),
    .busy(busy), .read_file(read_file), .file_index(file_index),
    .line_index(line_index), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_slice(out_slice),
    .out_last(out_last), .done(done)
`ifdef SLICE_PARITY_EN
    , .col_parity(col_parity)
`endif
  );

  always #5 clk = ~clk;

  // Reader contents: file 1023 carries the parity corner words, all others are hashed.
  function automatic logic [24:0] gen(input logic [9:0] f, input logic [5:0] l);
    logic [31:0] h;
    if (f == 10'd1023 && l == 6'd0) return 25'h1FFFFFF;
    if (f == 10'd1023 && l == 6'd1) return 25'h0000001;
    if (f == 10'd1023 && l == 6'd2) return 25'h0000021;
    h = salt ^ ({22'b0, f} * 32'h9E3779B1) ^ ({26'b0, l} * 32'h85EBCA77);
    h = h ^ (h >> 15);
    h = h * 32'h2C1B3C6D;
    h = h ^ (h >> 13);
    return h[24:0];
  endfunction

  function automatic logic [4:0] pref(input logic [24:0] d);
    logic [4:0] p;
    for (int x = 0; x < 5; x++) begin
      p[x] = 1'b0;
      for (int y = 0; y < 5; y++) p[x] = p[x] ^ d[5*y+x];
    end
    return p;
  endfunction

  always @(posedge clk) if (read_file) rd_file <= file_index;
  always_comb data_in = gen(rd_file, line_index);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high + start noise; mode 1: random ready; mode 2: 10-cycle stall from cycle 3
  task automatic run_pass(input int f, input int mode);
    int          idx = 0;
    int          cyc;
    bit          held = 0;
    bit          rdy;
    bit          seen_done = 0;
    logic [24:0] hd;
    logic [5:0]  hs;
    logic        hl;
    chk("idle_busy", busy, 0);
    start = 1'b1; file_idx_in = 10'(f); out_ready = 1'b0;
    tick(); cyc = 1;
    chk("load_read_file", read_file, 1);
    chk("load_busy", busy, 1);
    chk("load_file_index", file_index, f);
    start = (mode == 0); file_idx_in = 10'(f) ^ 10'h155;
    tick(); cyc = 2;
    chk("stream_read_file", read_file, 0);
    chk("stream_line0", line_index, 0);
    chk("stream_valid_c2", out_valid, 0);
    while (!seen_done && cyc < 2000) begin
      chk("file_index_hold", file_index, f);
      if (done) begin
        seen_done = 1;
        chk("done_count", idx, 64);
        chk("done_valid", out_valid, 0);
        if (mode == 0) chk("done_cycle", cyc, 67);
        start = (mode == 0);
      end else begin
        if (mode == 0 && cyc >= 3 && cyc <= 66) chk("no_bubble", out_valid, 1);
        if (mode == 0 && cyc == 66) chk("line_sat", line_index, 63);
        if (held) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, hd);
          chk("stall_slice", out_slice, hs);
          chk("stall_last", out_last, hl);
        end
        if (mode == 2 && cyc >= 3 && cyc < 13) begin
          chk("bp_slice", out_slice, 0);
          chk("bp_line", line_index, 1);
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom % 2) == 1;
          default: rdy = !(cyc >= 3 && cyc < 13);
        endcase
        if (out_valid && rdy) begin
          if (mode == 0) chk("xfer_cycle", cyc, idx + 3);
          chk("xfer_slice", out_slice, idx);
          chk("xfer_data", out_data, gen(10'(f), 6'(idx)));
          chk("xfer_last", out_last, idx == 63);
`ifdef SLICE_PARITY_EN
          chk("xfer_parity", col_parity, pref(gen(10'(f), 6'(idx))));
`endif
          idx++;
        end
        held = out_valid && !rdy;
        hd = out_data; hs = out_slice; hl = out_last;
        out_ready = rdy;
      end
      tick(); cyc++;
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    start = 1'b0; out_ready = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    if (mode == 0) chk("post_cycle", cyc, 68);
  endtask

  initial begin
    bit found;
    salt = $urandom;
    rst = 1'b1; start = 1'b0; file_idx_in = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_file_index", file_index, 0);
    rst = 1'b0;
    tick();
    chk("idle_done", done, 0);

    run_pass(3, 0);
    run_pass(int'($urandom_range(0, 1022)), 1);
    run_pass(int'($urandom_range(0, 1022)), 1);
    run_pass(5, 2);
    run_pass(1023, 0);
`ifdef SLICE_PARITY_EN
    chk("parity_ones", pref(25'h1FFFFFF), 5'b11111);
`endif

    // reset while slice 20 is pending
    start = 1'b1; file_idx_in = 10'd9; out_ready = 1'b0;
    tick();
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 600 && !found; n++) begin
      if (out_valid && out_slice == 6'd20) found = 1;
      else begin
        out_ready = ($urandom % 2) == 1;
        tick();
      end
    end
    out_ready = 1'b0;
    chk("rst_found_slice20", found, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_slice", out_slice, 0);
    chk("arst_last", out_last, 0);
    chk("arst_line", line_index, 0);
    chk("arst_file_index", file_index, 0);
    chk("arst_read_file", read_file, 0);
    chk("arst_done", done, 0);
`ifdef SLICE_PARITY_EN
    chk("arst_parity", col_parity, 0);
`endif
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle", busy, 0);
    run_pass(7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
